// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the multiply/divide issue controller: operator encoding
// (common with the datapath) and the controller state encoding.
package ibex_multdiv_issue_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } issue_state_e;

  function automatic logic is_mult_op(input logic [1:0] op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_watchdog.sv
// Saturating cycle counter with a sticky error flag; err_o rises on the clock
// edge that completes LIMIT counted cycles and holds until reset.
module ibex_multdiv_watchdog #(
  parameter int unsigned LIMIT = 40
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic err_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // clr_i wins over run_i so a fresh BUSY/DRAIN entry always starts from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (run_i && (cnt_q != LIMIT_C)) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LIMIT_C - 1'b1) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue/writeback controller around the iterative mult/div datapath.
// Optional result cache for repeated requests: IBEX_MULTDIV_RESULT_CACHE_EN.
module ibex_multdiv_issue #(
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_operator_i,
  input  logic [1:0]       req_signed_mode_i,
  input  logic [31:0]      req_op_a_i,
  input  logic [31:0]      req_op_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             kill_i,
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic [1:0]       md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  input  logic [31:0]      md_result_i,
  input  logic             md_valid_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             timeout_err_o
);

  import ibex_multdiv_issue_pkg::*;

  issue_state_e     state_q;
  logic             mult_en_q;
  logic             div_en_q;
  logic [1:0]       operator_q;
  logic [1:0]       signed_mode_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic             wb_valid_q;
  logic [31:0]      wb_result_q;
  logic [TAG_W-1:0] wb_tag_q;

  logic             accept;
  logic             cache_hit;
  logic [31:0]      cache_result;
  logic             wd_run;
  logic             wd_clr;

  assign accept = (state_q == ST_IDLE) && req_valid_i && !kill_i;

`ifdef IBEX_MULTDIV_RESULT_CACHE_EN
  logic        cache_valid_q;
  logic [1:0]  cache_operator_q;
  logic [1:0]  cache_signed_mode_q;
  logic [31:0] cache_op_a_q;
  logic [31:0] cache_op_b_q;
  logic [31:0] cache_result_q;

  assign cache_hit = cache_valid_q &&
                     (cache_operator_q    == req_operator_i) &&
                     (cache_signed_mode_q == req_signed_mode_i) &&
                     (cache_op_a_q        == req_op_a_i) &&
                     (cache_op_b_q        == req_op_b_i);
  assign cache_result = cache_result_q;

  // Only results that actually reach writeback are remembered; killed ones are not.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cache_valid_q       <= 1'b0;
      cache_operator_q    <= '0;
      cache_signed_mode_q <= '0;
      cache_op_a_q        <= '0;
      cache_op_b_q        <= '0;
      cache_result_q      <= '0;
    end else if ((state_q == ST_BUSY) && md_valid_i && !kill_i) begin
      cache_valid_q       <= 1'b1;
      cache_operator_q    <= operator_q;
      cache_signed_mode_q <= signed_mode_q;
      cache_op_a_q        <= op_a_q;
      cache_op_b_q        <= op_b_q;
      cache_result_q      <= md_result_i;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  assign wd_run = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
  assign wd_clr = (accept && !cache_hit) ||
                  ((state_q == ST_BUSY) && kill_i && !md_valid_i);

  ibex_multdiv_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (wd_run),
    .clr_i  (wd_clr),
    .err_o  (timeout_err_o)
  );

  // Enables drop on the edge that sees md_valid_i so the datapath never relaunches;
  // in DRAIN they stay up because the datapath freezes if they fall mid-operation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      mult_en_q     <= 1'b0;
      div_en_q      <= 1'b0;
      operator_q    <= '0;
      signed_mode_q <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      wb_valid_q    <= 1'b0;
      wb_result_q   <= '0;
      wb_tag_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            operator_q    <= req_operator_i;
            signed_mode_q <= req_signed_mode_i;
            op_a_q        <= req_op_a_i;
            op_b_q        <= req_op_b_i;
            wb_tag_q      <= req_tag_i;
            if (cache_hit) begin
              state_q     <= ST_RESP;
              wb_valid_q  <= 1'b1;
              wb_result_q <= cache_result;
            end else begin
              state_q   <= ST_BUSY;
              mult_en_q <= is_mult_op(req_operator_i);
              div_en_q  <= !is_mult_op(req_operator_i);
            end
          end
        end
        ST_BUSY: begin
          if (md_valid_i) begin
            mult_en_q <= 1'b0;
            div_en_q  <= 1'b0;
            if (kill_i) begin
              state_q <= ST_IDLE;
            end else begin
              state_q     <= ST_RESP;
              wb_valid_q  <= 1'b1;
              wb_result_q <= md_result_i;
            end
          end else if (kill_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (md_valid_i) begin
            mult_en_q <= 1'b0;
            div_en_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (wb_ready_i || kill_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o      = (state_q == ST_IDLE);
  assign md_mult_en_o     = mult_en_q;
  assign md_div_en_o      = div_en_q;
  assign md_operator_o    = operator_q;
  assign md_signed_mode_o = signed_mode_q;
  assign md_op_a_o        = op_a_q;
  assign md_op_b_o        = op_b_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_result_o      = wb_result_q;
  assign wb_tag_o         = wb_tag_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: directed and random transactions against an
// arithmetic mult/div model that also plays the datapath.
module tb_ibex_multdiv_issue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_operator_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic [4:0]  req_tag_i;
  logic        kill_i;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic [31:0] md_result_i;
  logic        md_valid_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_tag_o;
  logic        timeout_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_multdiv_issue #(
    .TAG_W       (5),
    .TIMEOUT_CYC (40)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_operator_i    (req_operator_i),
    .req_signed_mode_i (req_signed_mode_i),
    .req_op_a_i        (req_op_a_i),
    .req_op_b_i        (req_op_b_i),
    .req_tag_i         (req_tag_i),
    .kill_i            (kill_i),
    .md_mult_en_o      (md_mult_en_o),
    .md_div_en_o       (md_div_en_o),
    .md_operator_o     (md_operator_o),
    .md_signed_mode_o  (md_signed_mode_o),
    .md_op_a_o         (md_op_a_o),
    .md_op_b_o         (md_op_b_o),
    .md_result_i       (md_result_i),
    .md_valid_i        (md_valid_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_result_o       (wb_result_o),
    .wb_tag_o          (wb_tag_o),
    .timeout_err_o     (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  // RISC-V M-extension semantics computed with wide plain arithmetic.
  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0]  ea;
    logic signed [65:0]  eb;
    logic signed [131:0] p;
    logic signed [65:0]  q;
    ea = sm[0] ? {{34{a[31]}}, a} : {34'b0, a};
    eb = sm[1] ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = ea / eb;
        return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = ea % eb;
        return q[31:0];
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] sm,
                               input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    req_valid_i       = 1'b1;
    req_operator_i    = op;
    req_signed_mode_i = sm;
    req_op_a_i        = a;
    req_op_b_i        = b;
    req_tag_i         = tag;
    tick();
    req_valid_i       = 1'b0;
    req_op_a_i        = $urandom;
    req_op_b_i        = $urandom;
    req_tag_i         = 5'($urandom);
  endtask

  task automatic checkReset(input string nm);
    checkOutput({nm, "_ready"}, 64'(req_ready_o), 64'd1);
    checkOutput({nm, "_en"}, 64'({md_mult_en_o, md_div_en_o}), 64'd0);
    checkOutput({nm, "_md_regs"}, {28'd0, md_operator_o, md_signed_mode_o, md_op_a_o | md_op_b_o}, 64'd0);
    checkOutput({nm, "_wb"}, {26'd0, wb_valid_o, wb_tag_o, wb_result_o}, 64'd0);
    checkOutput({nm, "_err"}, 64'(timeout_err_o), 64'd0);
  endtask

  // One full transaction: lat = cycles until the datapath model pulses valid,
  // kill_at = BUSY cycle carrying kill (0 = none), stall = wb_ready low cycles.
  task automatic doOp(input string nm, input logic [1:0] op, input logic [1:0] sm,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                      input int lat, input int kill_at, input int stall, input bit kill_resp);
    logic [31:0] res;
    bit          is_mul;
    int          en_cnt;
    int          wrong_en;
    int          op_bad;
    int          early;
    res      = refModel(op, sm, a, b);
    is_mul   = (op < 2'd2);
    en_cnt   = 0;
    wrong_en = 0;
    op_bad   = 0;
    early    = 0;
    checkOutput({nm, "_ready_idle"}, 64'(req_ready_o), 64'd1);
    applyStimulus(op, sm, a, b, tag);
    checkOutput({nm, "_ready_busy"}, 64'(req_ready_o), 64'd0);
    for (int c = 1; c <= lat; c++) begin
      en_cnt   += int'(is_mul ? md_mult_en_o : md_div_en_o);
      wrong_en += int'(is_mul ? md_div_en_o : md_mult_en_o);
      if (md_operator_o !== op || md_signed_mode_o !== sm || md_op_a_o !== a || md_op_b_o !== b)
        op_bad++;
      if (wb_valid_o !== 1'b0 || req_ready_o !== 1'b0)
        early++;
      kill_i      = (c == kill_at);
      md_valid_i  = (c == lat);
      md_result_i = (c == lat) ? res : $urandom;
      tick();
      kill_i     = 1'b0;
      md_valid_i = 1'b0;
    end
    checkOutput({nm, "_en_cycles"}, 64'(en_cnt), 64'(lat));
    checkOutput({nm, "_wrong_en"}, 64'(wrong_en), 64'd0);
    checkOutput({nm, "_operands_stable"}, 64'(op_bad), 64'd0);
    checkOutput({nm, "_no_early_wb"}, 64'(early), 64'd0);
    checkOutput({nm, "_en_off"}, 64'({md_mult_en_o, md_div_en_o}), 64'd0);
    if (kill_at != 0) begin
      checkOutput({nm, "_killed_ready"}, 64'(req_ready_o), 64'd1);
      checkOutput({nm, "_killed_wb"}, 64'(wb_valid_o), 64'd0);
    end else begin
      for (int s = 0; s <= stall; s++) begin
        checkOutput({nm, "_wb_valid"}, 64'(wb_valid_o), 64'd1);
        checkOutput({nm, "_wb_result"}, 64'(wb_result_o), 64'(res));
        checkOutput({nm, "_wb_tag"}, 64'(wb_tag_o), 64'(tag));
        checkOutput({nm, "_ready_resp"}, 64'(req_ready_o), 64'd0);
        wb_ready_i = (s == stall) && !kill_resp;
        kill_i     = (s == stall) && kill_resp;
        tick();
        wb_ready_i = 1'b0;
        kill_i     = 1'b0;
      end
      checkOutput({nm, "_wb_done"}, 64'(wb_valid_o), 64'd0);
      checkOutput({nm, "_ready_after"}, 64'(req_ready_o), 64'd1);
    end
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [1:0]  r_sm;
    int          r_lat;
    int          r_kill;
    rst_ni            = 1'b0;
    req_valid_i       = 1'b0;
    req_operator_i    = '0;
    req_signed_mode_i = '0;
    req_op_a_i        = '0;
    req_op_b_i        = '0;
    req_tag_i         = '0;
    kill_i            = 1'b0;
    md_result_i       = '0;
    md_valid_i        = 1'b0;
    wb_ready_i        = 1'b0;
    tick();
    tick();
    checkReset("reset");
    rst_ni = 1'b1;
    tick();

    doOp("mull", 2'd0, 2'd0, 32'd7, 32'd6, 5'd3, 34, 0, 0, 1'b0);
    doOp("div", 2'd2, 2'd3, 32'hFFFF_FFEC, 32'd3, 5'd17, 37, 0, 0, 1'b0);
    doOp("rem_kill", 2'd3, 2'd0, 32'd100, 32'd7, 5'd9, 20, 5, 0, 1'b0);
    doOp("kill_valid", 2'd2, 2'd0, 32'd50, 32'd5, 5'd1, 6, 6, 0, 1'b0);
    doOp("stall", 2'd1, 2'd3, 32'h1234_5678, 32'h8765_4321, 5'd30, 10, 0, 4, 1'b0);
    doOp("resp_kill", 2'd0, 2'd1, 32'hDEAD_BEEF, 32'd3, 5'd12, 8, 0, 2, 1'b1);

    req_valid_i = 1'b1;
    kill_i      = 1'b1;
    tick();
    req_valid_i = 1'b0;
    kill_i      = 1'b0;
    checkOutput("idle_kill_ready", 64'(req_ready_o), 64'd1);
    checkOutput("idle_kill_en", 64'({md_mult_en_o, md_div_en_o}), 64'd0);

    for (int i = 0; i < 20; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_sm   = (r_op >= 2'd2) ? (($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0) : 2'($urandom_range(0, 3));
      r_lat  = $urandom_range(1, 37);
      r_kill = ($urandom_range(0, 4) == 0) ? $urandom_range(1, r_lat) : 0;
      doOp("rand", r_op, r_sm, $urandom, $urandom, 5'($urandom), r_lat, r_kill,
           $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Datapath never answers: error appears after 40 counted BUSY edges.
    applyStimulus(2'd1, 2'd0, 32'd5, 32'd9, 5'd4);
    for (int e = 1; e <= 45; e++) begin
      tick();
      checkOutput("timeout_err", 64'(timeout_err_o), (e >= 40) ? 64'd1 : 64'd0);
    end
    checkOutput("timeout_en_held", 64'(md_mult_en_o), 64'd1);
    checkOutput("timeout_ready", 64'(req_ready_o), 64'd0);
    rst_ni = 1'b0;
    tick();
    checkReset("timeout_reset");
    rst_ni = 1'b1;
    tick();
    checkOutput("post_reset_ready", 64'(req_ready_o), 64'd1);

`ifdef IBEX_MULTDIV_RESULT_CACHE_EN
    doOp("cache_first", 2'd1, 2'd3, 32'h8000_0000, 32'd2, 5'd7, 30, 0, 0, 1'b0);
    applyStimulus(2'd1, 2'd3, 32'h8000_0000, 32'd2, 5'd8);
    checkOutput("cache_wb_valid", 64'(wb_valid_o), 64'd1);
    checkOutput("cache_result", 64'(wb_result_o), 64'hFFFF_FFFF);
    checkOutput("cache_tag", 64'(wb_tag_o), 64'd8);
    checkOutput("cache_no_en", 64'({md_mult_en_o, md_div_en_o}), 64'd0);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    checkOutput("cache_done_ready", 64'(req_ready_o), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
